mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 22 ++
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the pipeline and the iterative
// multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply (shift-add) / divide (restoring) unit, one bit per cycle
// on operand magnitudes, with sign fix-up folded into the final iteration.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           CLK,
  input  logic           RESET,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t             state, state_nxt;
  logic               busy, done, accept, last_iter;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, iter_nxt, prod_signed;
  logic [WIDTH-1:0]   opnd, addend, a_mag, b_mag, quot, rem;
  logic [WIDTH:0]     add_sum, trial, diff;
  logic               is_div, neg_lo, neg_rem;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   result1_q, result2_q;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          busy      = 1'b1;
          state_nxt = COMPUTING;
        end
      end
      COMPUTING: begin
        busy = 1'b1;
        if (count == LAST_ITER) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.Start) begin
          busy      = 1'b1;
          state_nxt = COMPUTING;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (RESET) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

  assign accept    = (state != COMPUTING) && bus.Start;
  assign last_iter = (state == COMPUTING) && (count == LAST_ITER);

  assign a_neg = bus.MCycleOp[1] & bus.Operand1[WIDTH-1];
  assign b_neg = bus.MCycleOp[1] & bus.Operand2[WIDTH-1];
  assign a_mag = a_neg ? -bus.Operand1 : bus.Operand1;
  assign b_mag = b_neg ? -bus.Operand2 : bus.Operand2;

  // Multiply: acc = {partial sum, remaining multiplier}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    addend   = acc[0] ? opnd : {WIDTH{1'b0}};
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    trial    = acc[2*WIDTH-1:WIDTH-1];
    diff     = trial - {1'b0, opnd};
    iter_nxt = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH]) iter_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             iter_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign prod_signed = neg_lo ? -iter_nxt : iter_nxt;
  assign quot        = iter_nxt[WIDTH-1:0];
  assign rem         = iter_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count     <= '0;
      acc       <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_rem   <= 1'b0;
      result1_q <= '0;
      result2_q <= '0;
    end else if (accept) begin
      count   <= '0;
      is_div  <= bus.MCycleOp[0];
      opnd    <= bus.MCycleOp[0] ? b_mag : a_mag;
      acc     <= {{WIDTH{1'b0}}, (bus.MCycleOp[0] ? a_mag : b_mag)};
      // A zero divisor leaves the quotient all-ones regardless of sign mode.
      neg_lo  <= (a_neg ^ b_neg) && !(bus.MCycleOp[0] && (bus.Operand2 == '0));
      neg_rem <= a_neg;
    end else if (state == COMPUTING) begin
      count <= count + 1'b1;
      acc   <= iter_nxt;
      if (last_iter) begin
        if (is_div) begin
          result1_q <= neg_lo  ? -quot : quot;
          result2_q <= neg_rem ? -rem  : rem;
        end else begin
          result1_q <= prod_signed[WIDTH-1:0];
          result2_q <= prod_signed[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.Result1 = result1_q;
  assign bus.Result2 = result2_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors push expected results,
// a negedge monitor pops and compares on every Done pulse.
module tb_mult_div_unit;
  logic CLK = 1'b0;
  logic RESET;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (bus.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got Done=1 with results %h_%h, expected no Done",
                 bus.Result2, bus.Result1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {bus.Result2, bus.Result1}, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one operation from IDLE; returns Busy-cycle count and Done latency.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2, input bit chg,
                        output int nbusy, output int lat);
    exp_q.push_back({e2, e1});
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.Start    = 1'b1;
    nbusy = 0;
    lat   = -1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.Done && c > 0) begin
        lat = c;
        break;
      end
      if (bus.Busy) nbusy++;
      step();
      bus.Start = 1'b0;
      if (chg && c == 0) begin
        bus.Operand1 = ~a;
        bus.Operand2 = 32'h5;
        bus.MCycleOp = ~op;
      end
    end
    step();
  endtask

  task automatic wait_done(output bit ok, output int nlow);
    ok   = 1'b0;
    nlow = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      #2;
      if (!bus.Busy) nlow++;
      if (bus.Done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, e1, e2;
    bit          chg;
  } vec_t;

  vec_t vecs[$];
  int nbusy, lat, nlow;
  bit ok;

  initial begin
    vecs = '{
      '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0},
      '{2'b10, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0},
      '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'h00000006, 1'b0},
      '{2'b01, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0},
      '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0},
      '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0},
      '{2'b01, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b0},
      '{2'b11, 32'h80000001, 32'h00000000, 32'hFFFFFFFF, 32'h80000001, 1'b0},
      '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0},
      '{2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1},
      '{2'b10, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0},
      '{2'b11, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0}
    };

    RESET        = 1'b1;
    bus.Start    = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    step();
    bus.Start = 1'b1;
    #1;
    check("busy_in_reset", 64'(bus.Busy), 64'd0);
    check("done_in_reset", 64'(bus.Done), 64'd0);
    bus.Start = 1'b0;
    step();
    RESET = 1'b0;
    #1;
    check("reset_results", {bus.Result2, bus.Result1}, 64'd0);
    check("idle_busy", 64'(bus.Busy), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e1, vecs[i].e2, vecs[i].chg, nbusy, lat);
      if (i == 0) begin
        check("busy_cycles", 64'(nbusy), 64'd33);
        check("done_latency", 64'(lat), 64'd33);
      end
    end

    // Abort mid-operation with reset; no Done and results cleared.
    bus.MCycleOp = 2'b00;
    bus.Operand1 = 32'h00000003;
    bus.Operand2 = 32'h00000005;
    bus.Start    = 1'b1;
    step();
    bus.Start = 1'b0;
    repeat (9) step();
    RESET = 1'b1;
    #1;
    check("busy_during_reset", 64'(bus.Busy), 64'd0);
    step();
    RESET = 1'b0;
    #1;
    check("abort_busy", 64'(bus.Busy), 64'd0);
    check("abort_results", {bus.Result2, bus.Result1}, 64'd0);
    repeat (40) step();
    check("abort_no_done_results", {bus.Result2, bus.Result1}, 64'd0);
    run_op(2'b00, 32'h00000003, 32'h00000005, 32'd15, 32'd0, 1'b0, nbusy, lat);
    check("post_reset_latency", 64'(lat), 64'd33);

    // Back-to-back with Start held high.
    check("idle_busy_before_b2b", 64'(bus.Busy), 64'd0);
    exp_q.push_back({32'd2, 32'd14});
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    bus.MCycleOp = 2'b01;
    bus.Operand1 = 32'd100;
    bus.Operand2 = 32'd7;
    bus.Start    = 1'b1;
    wait_done(ok, nlow);
    check("b2b_first_done", 64'(ok), 64'd1);
    check("b2b_first_busy_low", 64'(nlow), 64'd0);
    bus.MCycleOp = 2'b10;
    bus.Operand1 = 32'hFFFFFFFD;
    bus.Operand2 = 32'h00000007;
    wait_done(ok, nlow);
    check("b2b_second_done", 64'(ok), 64'd1);
    check("b2b_second_busy_low", 64'(nlow), 64'd0);
    bus.Start = 1'b0;
    #1;
    check("done_busy_no_start", 64'(bus.Busy), 64'd0);
    repeat (3) step();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
